bus_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one valid/ready memory bus between NM masters (core I/D ports, debug, DMA).

---
 rtl/bus_rr_arbiter_if.sv | 49 ++++
 rtl/bus_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter_if
//   Bundles the request side (NM masters) and the single slave bus that the
//   round-robin arbiter sits between.
//
//   Modports
//     master : the arbiter's view. It takes the r_* requests in, drives the
//              r_ready/r_rdata completions back, and acts as bus master on
//              the s_* side.
//     slave  : the environment's view (the masters plus the memory slave).
//              It is the exact mirror of the master modport.
//
//   Signals
//     r_valid  [NM]     per-master request, held until that master's r_ready
//     r_ready  [NM]     one-hot, single-cycle completion strobe
//     r_addr   [NM*32]  master i address at [32*i+:32]
//     r_wdata  [NM*32]  master i write data at [32*i+:32]
//     r_wstrb  [NM*4]   master i byte strobes at [4*i+:4], 0 = read
//     r_rdata  [32]     read data broadcast to every master
//     s_valid/s_ready   slave handshake
//     s_addr/s_wdata/s_wstrb/s_rdata  slave bus payload
// ---------------------------------------------------------------------------
interface bus_rr_arbiter_if #(
  parameter int NM = 4
);
  logic [NM-1:0]    r_valid;
  logic [NM-1:0]    r_ready;
  logic [NM*32-1:0] r_addr;
  logic [NM*32-1:0] r_wdata;
  logic [NM*4-1:0]  r_wstrb;
  logic [31:0]      r_rdata;

  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic [3:0]       s_wstrb;
  logic [31:0]      s_rdata;

  modport master (
    input  r_valid, r_addr, r_wdata, r_wstrb, s_ready, s_rdata,
    output r_ready, r_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport slave (
    output r_valid, r_addr, r_wdata, r_wstrb, s_ready, s_rdata,
    input  r_ready, r_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//   Round-robin arbiter sharing one valid/ready memory bus between NM
//   masters (core I/D ports, debug, DMA). One IDLE cycle picks the next
//   requester after the last one served; the grant is then held in BUSY
//   until the slave completes the transfer.
//
//   Parameters
//     NM         number of masters (2..8)
//     TO_CYCLES  transfer timeout in cycles (only with BUS_ARB_TIMEOUT_EN)
//
//   Ports
//     clk     clock, all state on the rising edge
//     resetn  asynchronous active-low reset
//     bus     bus_rr_arbiter_if.master (request side + slave side)
//     err     single-cycle timeout pulse, tied 0 when the timeout is absent
//
//   Optional feature
//     `define BUS_ARB_TIMEOUT_EN enables the per-transfer timeout: a transfer
//     still waiting on s_ready after TO_CYCLES BUSY cycles is completed to
//     the master with r_rdata = 32'hFFFF_FFFF and err = 1. s_ready on that
//     same cycle takes priority and completes normally.
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int NM        = 4,
  parameter int TO_CYCLES = 256
) (
  input  logic                clk,
  input  logic                resetn,
  bus_rr_arbiter_if.master    bus,
  output logic                err
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  if (NM < 2 || NM > 8) begin : g_nm_check
    $error("bus_rr_arbiter: NM must be in 2..8");
  end
  if (TO_CYCLES < 2) begin : g_to_check
    $error("bus_rr_arbiter: TO_CYCLES must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last;
  logic [GW-1:0]   next_grant;
  logic [GW+4:0]   data_base;
  logic [GW+1:0]   strb_base;
  logic            done_ok;
  logic            done_to;
  logic            done;

  // First requester found scanning last+1, last+2, ... wrapping at NM.
  // Starting one past the previous winner is what bounds every master's
  // wait to NM-1 transfers.
  function automatic logic [GW-1:0] rr_pick(input logic [NM-1:0] req,
                                            input logic [GW-1:0] lst);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(lst) + k) % NM;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign next_grant = rr_pick(bus.r_valid, last);
  assign done_ok    = (state == BUSY) && bus.s_ready;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES) + 1;

  logic [CW-1:0] to_cnt;

  // The counter value equals the number of BUSY cycles already spent
  // without s_ready, so it reads TO_CYCLES-1 on the TO_CYCLES-th BUSY cycle.
  assign done_to = (state == BUSY) && !bus.s_ready &&
                   (to_cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      if (|bus.r_valid) begin
        to_cnt <= '0;
      end
    end else if (!bus.s_ready && !done_to) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  assign err = done_to;
`else
  assign done_to = 1'b0;
  assign err     = 1'b0;
`endif

  assign done = done_ok | done_to;

  // Arbitration / transfer control
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(NM - 1);
    end else begin
      case (state)
        IDLE: begin
          // s_ready seen here belongs to no transfer and is ignored.
          if (|bus.r_valid) begin
            grant <= next_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          // The grant is frozen here: newer requests wait for the next
          // IDLE cycle even if the granted master drops r_valid.
          if (done) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // s_valid comes straight from the state register, so an asynchronous
  // reset removes it without waiting for a clock edge.
  assign bus.s_valid = (state == BUSY);

  assign data_base = {grant, 5'b0};
  assign strb_base = {grant, 2'b0};

  always_comb begin
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    if (state == BUSY) begin
      bus.s_addr  = bus.r_addr[data_base +: 32];
      bus.s_wdata = bus.r_wdata[data_base +: 32];
      bus.s_wstrb = bus.r_wstrb[strb_base +: 4];
    end
  end

  always_comb begin
    bus.r_ready = '0;
    if (done) begin
      bus.r_ready[grant] = 1'b1;
    end
  end

  // Read data is a pass-through; masters qualify it with their own r_ready.
  assign bus.r_rdata = done_to ? 32'hFFFF_FFFF : bus.s_rdata;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

  localparam int NM = 4;
  localparam int TO = 8;

  logic clk;
  logic resetn;
  logic err;

  bus_rr_arbiter_if #(.NM(NM)) bus ();

  bus_rr_arbiter #(.NM(NM), .TO_CYCLES(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus state owned by the bench
  logic [31:0]   a_addr  [NM];
  logic [31:0]   a_wdata [NM];
  logic [3:0]    a_wstrb [NM];
  logic [NM-1:0] a_req;
  logic          t_sready;
  logic [31:0]   t_srdata;

  // Reference model state
  bit            m_busy;
  int            m_last;
  int            m_grant;
  int            m_cnt;
  logic [NM-1:0] m_arb_req;
  int            waits [NM];
  logic [NM-1:0] done_m;
  logic          prev_sv;
  int            order_q[$];
  int            done_cyc_q[$];
  int            n_err_seen;
  int            n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: the first requester strictly after the last winner.
  function automatic int rr_next(input int lst, input logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++) begin
      if (req[(lst + k) % NM]) return (lst + k) % NM;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      bus.r_addr[32*i +: 32]  = a_addr[i];
      bus.r_wdata[32*i +: 32] = a_wdata[i];
      bus.r_wstrb[4*i +: 4]   = a_wstrb[i];
    end
    bus.r_valid = a_req;
    bus.s_ready = t_sready;
    bus.s_rdata = t_srdata;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = NM - 1;
    m_cnt  = 0;
    for (int i = 0; i < NM; i++) waits[i] = 0;
  endtask

  task automatic complete();
    for (int j = 0; j < NM; j++) begin
      if (j != m_grant && m_arb_req[j]) waits[j]++;
    end
    chk("fair_wait", 32'(waits[m_grant] <= NM - 1), 32'd1);
    waits[m_grant] = 0;
    m_last = m_grant;
    m_busy = 1'b0;
    done_m[m_grant] = 1'b1;
    order_q.push_back(m_grant);
    done_cyc_q.push_back(cyc);
    n_done++;
  endtask

  // Called on the falling edge: compares this cycle's outputs, then
  // advances the model across the coming rising edge.
  task automatic sample();
    @(negedge clk);
    done_m = '0;
    if (err) n_err_seen++;
    if (!m_busy) begin
      chk("idle_svalid", 32'(bus.s_valid), 32'd0);
      chk("idle_rready", 32'(bus.r_ready), 32'd0);
      chk("idle_saddr",  bus.s_addr, 32'd0);
      chk("idle_swdata", bus.s_wdata, 32'd0);
      chk("idle_swstrb", 32'(bus.s_wstrb), 32'd0);
      chk("idle_err",    32'(err), 32'd0);
      if (a_req != '0) begin
        m_grant   = rr_next(m_last, a_req);
        m_arb_req = a_req;
        m_busy    = 1'b1;
        m_cnt     = 0;
      end
    end else begin
      chk("busy_svalid", 32'(bus.s_valid), 32'd1);
      chk("busy_saddr",  bus.s_addr, a_addr[m_grant]);
      chk("busy_swdata", bus.s_wdata, a_wdata[m_grant]);
      chk("busy_swstrb", 32'(bus.s_wstrb), 32'(a_wstrb[m_grant]));
      if (t_sready) begin
        chk("done_rready", 32'(bus.r_ready), 32'(1) << m_grant);
        chk("done_rdata",  bus.r_rdata, t_srdata);
        chk("done_err",    32'(err), 32'd0);
        complete();
      end
`ifdef BUS_ARB_TIMEOUT_EN
      else if (m_cnt == TO - 1) begin
        chk("to_rready", 32'(bus.r_ready), 32'(1) << m_grant);
        chk("to_rdata",  bus.r_rdata, 32'hFFFF_FFFF);
        chk("to_err",    32'(err), 32'd1);
        complete();
      end
`endif
      else begin
        chk("wait_rready", 32'(bus.r_ready), 32'd0);
        chk("wait_err",    32'(err), 32'd0);
        m_cnt++;
      end
    end
    prev_sv = bus.s_valid;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    a_req[i]   = 1'b1;
    a_addr[i]  = $urandom();
    a_wdata[i] = $urandom();
    a_wstrb[i] = 4'($urandom_range(15));
  endtask

  // spol: 0 = slave ready one cycle after s_valid, 1 = random, 2 = never
  task automatic run(input int ncyc, input logic [NM-1:0] rereq,
                     input bit rand_req, input int spol);
    for (int c = 0; c < ncyc; c++) begin
      sample();
      advance();
      for (int i = 0; i < NM; i++) begin
        if (done_m[i]) begin
          if (rereq[i]) new_req(i);
          else a_req[i] = 1'b0;
        end else if (rand_req && !a_req[i] && $urandom_range(3) == 0) begin
          new_req(i);
        end
      end
      case (spol)
        0:       t_sready = prev_sv && (done_m == '0);
        1:       t_sready = ($urandom_range(2) == 0);
        default: t_sready = 1'b0;
      endcase
      t_srdata = $urandom();
      drive();
    end
  endtask

  initial begin
    int base_err;
    resetn   = 1'b0;
    a_req    = '0;
    t_sready = 1'b0;
    t_srdata = '0;
    prev_sv  = 1'b0;
    done_m   = '0;
    m_arb_req = '0;
    m_grant  = 0;
    n_err_seen = 0;
    n_done   = 0;
    for (int i = 0; i < NM; i++) begin
      a_addr[i] = '0; a_wdata[i] = '0; a_wstrb[i] = '0;
    end
    model_reset();
    drive();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_svalid", 32'(bus.s_valid), 32'd0);
    chk("rst_rready", 32'(bus.r_ready), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_saddr",  bus.s_addr, 32'd0);
    advance();
    resetn = 1'b1;

    // 1: single read by master 2
    a_req = 4'b0100; a_addr[2] = 32'h100; a_wdata[2] = 32'h0; a_wstrb[2] = 4'h0;
    drive();
    sample();
    chk("t1_svalid_c1", 32'(bus.s_valid), 32'd0);
    advance();
    sample();
    chk("t1_svalid_c2", 32'(bus.s_valid), 32'd1);
    chk("t1_saddr", bus.s_addr, 32'h100);
    advance();
    t_sready = 1'b1; t_srdata = 32'hCAFE_0001; drive();
    sample();
    chk("t1_rready", 32'(bus.r_ready), 32'h4);
    chk("t1_rdata",  bus.r_rdata, 32'hCAFE_0001);
    advance();
    a_req = '0; t_sready = 1'b0; drive();

    // 2: all four from reset, slave ready one cycle after s_valid
    resetn = 1'b0;
    model_reset();
    advance();
    resetn = 1'b1;
    for (int i = 0; i < NM; i++) new_req(i);
    drive();
    order_q.delete(); done_cyc_q.delete();
    run(13, '0, 1'b0, 0);
    chk("t2_count", 32'(order_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < order_q.size(); k++) chk("t2_order", 32'(order_q[k]), 32'(k));
    for (int k = 1; k < done_cyc_q.size(); k++)
      chk("t2_period", 32'(done_cyc_q[k] - done_cyc_q[k-1]), 32'd3);

    // 3: masters 0 and 2 re-request immediately -> strict alternation
    order_q.delete();
    new_req(0); new_req(2); drive();
    run(20, 4'b0101, 1'b0, 0);
    chk("t3_count", 32'(order_q.size() >= 4), 32'd1);
    for (int k = 0; k < order_q.size(); k++)
      chk("t3_member", 32'(order_q[k] == 0 || order_q[k] == 2), 32'd1);
    for (int k = 1; k < order_q.size(); k++)
      chk("t3_alternate", 32'(order_q[k] != order_q[k-1]), 32'd1);
    run(8, '0, 1'b0, 0);

    // 4: write through master 3
    a_req = 4'b1000; a_addr[3] = 32'h300; a_wdata[3] = 32'h1234_5678; a_wstrb[3] = 4'b0011;
    t_sready = 1'b0; drive();
    sample();
    advance();
    sample();
    chk("t4_swdata", bus.s_wdata, 32'h1234_5678);
    chk("t4_swstrb", 32'(bus.s_wstrb), 32'h3);
    advance();
    t_sready = 1'b1; t_srdata = $urandom(); drive();
    sample();
    chk("t4_rready", 32'(bus.r_ready), 32'h8);
    advance();
    a_req = '0; t_sready = 1'b0; drive();

    // 5: reset in the middle of a transfer, then re-arbitration from NM-1
    new_req(1); new_req(2); drive();
    sample();
    advance();
    sample();
    advance();
    t_sready = 1'b1; drive();
    resetn = 1'b0;
    #1;
    chk("t5_svalid_async", 32'(bus.s_valid), 32'd0);
    chk("t5_rready_async", 32'(bus.r_ready), 32'd0);
    model_reset();
    advance();
    resetn = 1'b1; t_sready = 1'b0; drive();
    sample();
    advance();
    sample();
    chk("t5_rearb_addr", bus.s_addr, a_addr[1]);
    advance();
    t_sready = 1'b1; t_srdata = $urandom(); drive();
    sample();
    chk("t5_rready", 32'(bus.r_ready), 32'h2);
    advance();
    a_req[1] = 1'b0; t_sready = 1'b0; drive();
    run(8, '0, 1'b0, 0);

`ifdef BUS_ARB_TIMEOUT_EN
    // 6: slave never ready -> timeout on the TO-th BUSY cycle, next master served
    order_q.delete(); done_cyc_q.delete();
    base_err = n_err_seen;
    new_req(0); new_req(1); t_sready = 1'b0; drive();
    run(20, '0, 1'b0, 2);
    chk("t6_err_pulses", 32'(n_err_seen - base_err), 32'd2);
    chk("t6_served", 32'(order_q.size()), 32'd2);
    if (order_q.size() == 2) chk("t6_distinct", 32'(order_q[0] != order_q[1]), 32'd1);
    if (done_cyc_q.size() == 2) chk("t6_period", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd9);
`else
    base_err = n_err_seen;
`endif

    // Randomised traffic against the model, then drain
    run(800, '0, 1'b1, 1);
    run(30, '0, 1'b0, 0);
`ifndef BUS_ARB_TIMEOUT_EN
    chk("no_err_ever", 32'(n_err_seen - base_err), 32'd0);
`endif
    chk("rand_progress", 32'(n_done > 50), 32'd1);
    chk("drained_idle", 32'(bus.s_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
